// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave port: bus mode, default word width,
// idle reply value and the frame state encoding.
package spi_pkg;

    // Mode 0: {CPOL, CPHA} = 2'b00
    localparam logic [1:0] SPI_MODE    = 2'b00;
    localparam logic       SPI_CPOL    = SPI_MODE[1];
    localparam int         SPI_DATA_W  = 8;
    localparam logic [7:0] SPI_TX_IDLE = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus a history flop
// giving single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic global_clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and previous-value flop
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            prev_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave endpoint: oversamples sclk/ss/mosi in the global_clk domain
// and exposes received and reply words through valid/ready style handshakes.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int                DATA_W  = SPI_DATA_W,
    parameter logic [DATA_W-1:0] TX_IDLE = DATA_W'(SPI_TX_IDLE)
) (
    input  logic              global_clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // An empty shadow register means the master gets the idle pattern
    function automatic logic [DATA_W-1:0] next_reply(
        input logic              shadow_empty,
        input logic [DATA_W-1:0] shadow
    );
        if (shadow_empty) begin
            return TX_IDLE;
        end else begin
            return shadow;
        end
    endfunction

    logic       sclk_level_unused_s;
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       ss_sync_s;
    logic       ss_rise_s;
    logic       ss_fall_s;
    logic       mosi_sync_s;
    logic [1:0] mosi_edges_unused_s;

    spi_state_e        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] shadow_r;
    logic              tx_ready_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              rx_overrun_r;
    logic              miso_r;
    logic              busy_r;

    spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sync_sclk (
        .global_clk (global_clk),
        .reset      (reset),
        .din        (sclk),
        .sync       (sclk_level_unused_s),
        .rise       (sclk_rise_s),
        .fall       (sclk_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
        .global_clk (global_clk),
        .reset      (reset),
        .din        (ss),
        .sync       (ss_sync_s),
        .rise       (ss_rise_s),
        .fall       (ss_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .global_clk (global_clk),
        .reset      (reset),
        .din        (mosi),
        .sync       (mosi_sync_s),
        .rise       (mosi_edges_unused_s[0]),
        .fall       (mosi_edges_unused_s[1])
    );

    // Frame FSM, shift registers and both handshakes
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            rx_shift_r   <= {DATA_W{1'b0}};
            tx_shift_r   <= {DATA_W{1'b0}};
            shadow_r     <= {DATA_W{1'b0}};
            tx_ready_r   <= 1'b1;
            rx_data_r    <= {DATA_W{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
            miso_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= ~ss_sync_s;

            if (rx_ack) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    miso_r    <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    if (ss_fall_s) begin
                        state_r    <= ST_ACTIVE;
                        tx_shift_r <= next_reply(tx_ready_r, shadow_r);
                        tx_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise_s) begin
                        // Deselect mid-word throws the partial word away
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        miso_r    <= 1'b0;
                    end else begin
                        miso_r <= tx_shift_r[DATA_W-1];
                        if (sclk_rise_s) begin
                            rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_sync_s};
                            if (bit_cnt_r == LAST_BIT) begin
                                bit_cnt_r  <= {CNT_W{1'b0}};
                                rx_data_r  <= {rx_shift_r[DATA_W-2:0], mosi_sync_s};
                                rx_valid_r <= 1'b1;
                                if (rx_valid_r && !rx_ack) begin
                                    rx_overrun_r <= 1'b1;
                                end else begin
                                    rx_overrun_r <= rx_overrun_r;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else if (sclk_fall_s) begin
                            // Falling edge after the last bit starts the next reply word
                            if (bit_cnt_r == {CNT_W{1'b0}}) begin
                                tx_shift_r <= next_reply(tx_ready_r, shadow_r);
                                tx_ready_r <= 1'b1;
                            end else begin
                                tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            tx_shift_r <= tx_shift_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    miso_r    <= 1'b0;
                end
            endcase

            // Placed last so a load coinciding with a shadow copy still wins tx_ready
            if (tx_load && tx_ready_r) begin
                shadow_r   <= tx_data;
                tx_ready_r <= 1'b0;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign miso       = miso_r;
    assign tx_ready   = tx_ready_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign rx_overrun = rx_overrun_r;
    assign busy       = busy_r;

endmodule
